// File: rtl/raizing_rom_arbiter_if.sv
// rtl/raizing_rom_arbiter_if.sv - SDRAM bank read port shared by the ROM arbiter
interface raizing_rom_arbiter_if #(
  parameter int AW = 22
);
  logic [AW-1:0] BA_ADDR;
  logic          BA_RD;
  logic          BA_ACK;
  logic          BA_DOK;
  logic [15:0]   DATA_READ;

  modport master (
    output BA_ADDR,
    output BA_RD,
    input  BA_ACK,
    input  BA_DOK,
    input  DATA_READ
  );

  modport slave (
    input  BA_ADDR,
    input  BA_RD,
    output BA_ACK,
    output BA_DOK,
    output DATA_READ
  );
endinterface

// File: rtl/raizing_rom_arbiter.sv
// rtl/raizing_rom_arbiter.sv - N-channel cached ROM read arbiter onto one SDRAM bank port
module raizing_rom_arbiter #(
  parameter int              NCH    = 4,
  parameter int              AW     = 22,
  parameter logic [NCH-1:0]  WIDE   = '0,
  parameter logic [NCH-1:0]  PRIO   = '0,
  parameter logic [NCH*AW-1:0] OFFSET = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NCH-1:0]      CH_CS,
  input  logic [NCH*AW-1:0]   CH_ADDR,
  output logic [NCH*32-1:0]   CH_DOUT,
  output logic [NCH-1:0]      CH_OK,
  raizing_rom_arbiter_if.master ba
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   gch_q, gch_d;
  logic [CW-1:0]   rr_q, rr_d;
  logic [AW-1:0]   gaddr_q, gaddr_d;
  logic [AW-1:0]   ba_addr_q, ba_addr_d;
  logic            wide_q, wide_d;
  logic            wcnt_q, wcnt_d;
  logic [31:0]     buf_q, buf_d;

  logic [AW-1:0]   tag_q  [NCH];
  logic [31:0]     dout_q [NCH];
  logic [NCH-1:0]  valid_q;

  logic [NCH-1:0]  hit;
  logic [NCH-1:0]  pend;
  logic            gnt_vld;
  logic [CW-1:0]   gnt_idx;
  logic [CW-1:0]   rr_idx;

  // A channel hits when its cached tag matches the address it is presenting now
  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = valid_q[i] && (tag_q[i] == CH_ADDR[i*AW +: AW]);
    end
  end

  assign pend  = CH_CS & ~hit;
  assign CH_OK = CH_CS & hit;

  for (genvar g = 0; g < NCH; g++) begin : g_dout
    assign CH_DOUT[g*32 +: 32] = dout_q[g];
  end

  assign ba.BA_RD   = (state_q == S_REQ);
  assign ba.BA_ADDR = ba_addr_q;

  // Grant: lowest pending fixed-priority channel, else round-robin after the last non-priority grant
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend[i] && PRIO[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'(i);
      end
    end
    if (!gnt_vld) begin
      // Walk the search order backwards so the nearest candidate is written last
      for (int k = NCH; k >= 1; k--) begin
        rr_idx = CW'((int'(rr_q) + k) % NCH);
        if (pend[rr_idx] && !PRIO[rr_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = rr_idx;
        end
      end
    end
  end

  // Transaction sequencing: grant, hold the request until accepted, collect words, then fill
  always_comb begin
    state_d   = state_q;
    gch_d     = gch_q;
    rr_d      = rr_q;
    gaddr_d   = gaddr_q;
    ba_addr_d = ba_addr_q;
    wide_d    = wide_q;
    wcnt_d    = wcnt_q;
    buf_d     = buf_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          gch_d     = gnt_idx;
          gaddr_d   = CH_ADDR[gnt_idx*AW +: AW];
          ba_addr_d = CH_ADDR[gnt_idx*AW +: AW] + OFFSET[gnt_idx*AW +: AW];
          wide_d    = WIDE[gnt_idx];
          wcnt_d    = 1'b0;
          buf_d     = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (ba.BA_ACK) state_d = S_DATA;
      end
      S_DATA: begin
        if (ba.BA_DOK) begin
          if (!wcnt_q) buf_d[15:0]  = ba.DATA_READ;
          else         buf_d[31:16] = ba.DATA_READ;
          if (wcnt_q || !wide_q) state_d = S_DONE;
          else                   wcnt_d  = 1'b1;
        end
      end
      S_DONE: begin
        if (!PRIO[gch_q]) rr_d = gch_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      gch_q     <= '0;
      rr_q      <= '0;
      gaddr_q   <= '0;
      ba_addr_q <= '0;
      wide_q    <= 1'b0;
      wcnt_q    <= 1'b0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      gch_q     <= gch_d;
      rr_q      <= rr_d;
      gaddr_q   <= gaddr_d;
      ba_addr_q <= ba_addr_d;
      wide_q    <= wide_d;
      wcnt_q    <= wcnt_d;
      buf_q     <= buf_d;
    end
  end

  // Per-channel caches: filled against the latched address when a transaction finishes
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        tag_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else if (state_q == S_DONE) begin
      valid_q[gch_q] <= 1'b1;
      tag_q[gch_q]   <= gaddr_q;
      dout_q[gch_q]  <= wide_q ? buf_q : {16'h0000, buf_q[15:0]};
    end
  end
endmodule

// File: tb/tb_raizing_rom_arbiter.sv
// tb/tb_raizing_rom_arbiter.sv - self-checking bench for raizing_rom_arbiter
module tb_raizing_rom_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 22;
  localparam logic [NCH-1:0]    WIDE   = 4'b0010;
  localparam logic [NCH-1:0]    PRIO   = 4'b0001;
  localparam logic [NCH*AW-1:0] OFFSET = {22'h3FFFF0, 22'h000000, 22'h200000, 22'h000000};

  logic                clk;
  logic                rst;
  logic [NCH-1:0]      cs;
  logic [NCH*AW-1:0]   addr;
  logic [NCH*32-1:0]   dout;
  logic [NCH-1:0]      ok;

  raizing_rom_arbiter_if #(.AW(AW)) bus ();

  raizing_rom_arbiter #(
    .NCH(NCH), .AW(AW), .WIDE(WIDE), .PRIO(PRIO), .OFFSET(OFFSET)
  ) dut (
    .CLK(clk), .RESET(rst), .CH_CS(cs), .CH_ADDR(addr),
    .CH_DOUT(dout), .CH_OK(ok), .ba(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // SDRAM responder state
  int            ack_delay;
  bit            stray_en;
  int            proto_err;
  int            rd_count;
  int            phase;
  int            hold;
  logic [AW-1:0] raddr;
  logic [AW-1:0] req_q[$];
  logic [15:0]   mem_ovr[int];

  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    return a[15:0] ^ {a[21:16], a[9:0]} ^ 16'h5A3C;
  endfunction

  function automatic logic [AW-1:0] exp_ba(input int ch, input logic [AW-1:0] a);
    return a + OFFSET[ch*AW +: AW];
  endfunction

  function automatic logic [31:0] exp_dout(input int ch, input logic [AW-1:0] a);
    logic [AW-1:0] b;
    logic [AW-1:0] b1;
    b  = exp_ba(ch, a);
    b1 = b + 1'b1;
    if (WIDE[ch]) return {mem_word(b1), mem_word(b)};
    return {16'h0000, mem_word(b)};
  endfunction

  function automatic bit same_seq(input logic [AW-1:0] got[$], input logic [AW-1:0] want[$]);
    if (got.size() != want.size()) return 1'b0;
    foreach (want[i]) if (got[i] !== want[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_addr(input int ch, input logic [AW-1:0] a);
    addr[ch*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_all(input int budget, output bit done, output int rd_high);
    done = 1'b0;
    rd_high = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (bus.BA_RD) rd_high++;
      if ((ok & cs) == cs) done = 1'b1;
    end
  endtask

  // Bank model: request held until ACK after ack_delay cycles, then two consecutive words stream out
  initial begin
    bus.BA_ACK = 1'b0; bus.BA_DOK = 1'b0; bus.DATA_READ = '0;
    phase = 0; hold = 0; raddr = '0; rd_count = 0; proto_err = 0;
    forever begin
      @(negedge clk);
      bus.BA_ACK = 1'b0;
      bus.BA_DOK = 1'b0;
      if (phase == 3) begin
        bus.BA_DOK = 1'b1; bus.DATA_READ = mem_word(raddr + 1'b1); phase = 0;
      end else if (phase == 2) begin
        if (bus.BA_RD) proto_err++;
        bus.BA_DOK = 1'b1; bus.DATA_READ = mem_word(raddr); phase = 3;
      end else begin
        if (phase == 0 && bus.BA_RD) begin
          raddr = bus.BA_ADDR; req_q.push_back(raddr); rd_count++; hold = 0; phase = 1;
        end
        if (phase == 1) begin
          if (!bus.BA_RD || bus.BA_ADDR !== raddr) proto_err++;
          if (hold >= ack_delay) begin
            bus.BA_ACK = 1'b1; phase = 2;
          end else begin
            if (stray_en && hold == 2) begin
              bus.BA_DOK = 1'b1; bus.DATA_READ = 16'hDEAD;
            end
            hold++;
          end
        end
      end
    end
  end

  task automatic test_reset();
    cs = '0; addr = '0; rst = 1'b1; ack_delay = 0; stray_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.BA_RD !== 1'b0) begin failures++; $display("FAIL reset_ba_rd got=%b want=0", bus.BA_RD); end
    checks++; if (bus.BA_ADDR !== '0) begin failures++; $display("FAIL reset_ba_addr got=%h want=0", bus.BA_ADDR); end
    checks++; if (ok !== '0) begin failures++; $display("FAIL reset_ok got=%b want=0", ok); end
    checks++; if (dout !== '0) begin failures++; $display("FAIL reset_dout got=%h want=0", dout); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_narrow();
    logic [3:0] okseq;
    int n0, n1, lowcnt;
    mem_ovr[32'h100] = 16'hBEEF;
    n0 = rd_count;
    set_addr(0, 22'h000100);
    cs = 4'b0001;
    for (int k = 0; k < 4; k++) begin @(negedge clk); okseq[k] = ok[0]; end
    checks++; if (okseq !== 4'b1000) begin failures++; $display("FAIL narrow_latency got=%b want=1000", okseq); end
    checks++; if (dout[31:0] !== 32'h0000BEEF) begin failures++; $display("FAIL narrow_dout got=%h want=0000beef", dout[31:0]); end
    checks++; if (rd_count - n0 != 1) begin failures++; $display("FAIL narrow_fetches got=%0d want=1", rd_count - n0); end
    n1 = rd_count; lowcnt = 0;
    repeat (100) begin @(negedge clk); if (!ok[0]) lowcnt++; end
    checks++; if (rd_count != n1) begin failures++; $display("FAIL hit_traffic got=%0d want=0", rd_count - n1); end
    checks++; if (lowcnt != 0) begin failures++; $display("FAIL hit_ok_drop got=%0d want=0", lowcnt); end
  endtask

  task automatic test_wide();
    logic [4:0] okseq;
    mem_ovr[32'h200010] = 16'h1111;
    mem_ovr[32'h200011] = 16'h2222;
    req_q.delete();
    set_addr(1, 22'h000010);
    cs = 4'b0011;
    for (int k = 0; k < 5; k++) begin @(negedge clk); okseq[k] = ok[1]; end
    checks++; if (okseq !== 5'b10000) begin failures++; $display("FAIL wide_latency got=%b want=10000", okseq); end
    checks++; if (req_q.size() != 1 || req_q[0] !== 22'h200010) begin failures++; $display("FAIL wide_ba_addr got_n=%0d first=%h want=200010", req_q.size(), (req_q.size() > 0) ? req_q[0] : '0); end
    checks++; if (dout[63:32] !== 32'h22221111) begin failures++; $display("FAIL wide_dout got=%h want=22221111", dout[63:32]); end
    checks++; if (ok[0] !== 1'b1) begin failures++; $display("FAIL wide_ch0_hit got=%b want=1", ok[0]); end
  endtask

  task automatic test_wrap();
    bit done; int rdh;
    req_q.delete();
    set_addr(3, 22'h000020);
    cs = 4'b1011;
    wait_all(60, done, rdh);
    checks++; if (!done) begin failures++; $display("FAIL wrap_timeout got=%b want=1", done); end
    checks++; if (req_q.size() != 1 || req_q[0] !== 22'h000010) begin failures++; $display("FAIL wrap_ba_addr got_n=%0d first=%h want=000010", req_q.size(), (req_q.size() > 0) ? req_q[0] : '0); end
    checks++; if (dout[127:96] !== exp_dout(3, 22'h20)) begin failures++; $display("FAIL wrap_dout got=%h want=%h", dout[127:96], exp_dout(3, 22'h20)); end
  endtask

  task automatic test_prio_rr();
    logic [AW-1:0] want[$];
    bit done; int rdh; int base; bit seen;
    cs = '0;
    do_reset();
    set_addr(0, 22'h1000); set_addr(1, 22'h2000); set_addr(2, 22'h3000); set_addr(3, 22'h4000);
    req_q.delete();
    cs = 4'b1111;
    wait_all(200, done, rdh);
    want = '{exp_ba(0, 22'h1000), exp_ba(1, 22'h2000), exp_ba(2, 22'h3000), exp_ba(3, 22'h4000)};
    checks++; if (!done || !same_seq(req_q, want)) begin failures++; $display("FAIL prio_first_order got_n=%0d first=%h want_n=4 first=%h", req_q.size(), (req_q.size() > 0) ? req_q[0] : '0, want[0]); end
    set_addr(1, 22'h2100); set_addr(2, 22'h3100);
    req_q.delete();
    wait_all(200, done, rdh);
    want = '{exp_ba(1, 22'h2100), exp_ba(2, 22'h3100)};
    checks++; if (!done || !same_seq(req_q, want)) begin failures++; $display("FAIL rr_order got_n=%0d first=%h want_n=2 first=%h", req_q.size(), (req_q.size() > 0) ? req_q[0] : '0, want[0]); end
    set_addr(1, 22'h2200); set_addr(3, 22'h4200);
    req_q.delete();
    base = rd_count; seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin @(negedge clk); if (rd_count != base) seen = 1'b1; end
    checks++; if (!seen) begin failures++; $display("FAIL preempt_first_req got=%b want=1", seen); end
    set_addr(0, 22'h1100);
    wait_all(200, done, rdh);
    want = '{exp_ba(3, 22'h4200), exp_ba(0, 22'h1100), exp_ba(1, 22'h2200)};
    checks++; if (!done || !same_seq(req_q, want)) begin failures++; $display("FAIL preempt_order got_n=%0d second=%h want_n=3 second=%h", req_q.size(), (req_q.size() > 1) ? req_q[1] : '0, want[1]); end
  endtask

  task automatic test_addr_change();
    logic [AW-1:0] want[$];
    int base, early; bit done;
    req_q.delete();
    base = rd_count; early = 0; done = 1'b0;
    set_addr(2, 22'h40);
    repeat (2) @(negedge clk);
    set_addr(2, 22'h41);
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (ok[2] && rd_count - base < 2) early++;
      if ((ok & cs) == cs) done = 1'b1;
    end
    want = '{22'h40, 22'h41};
    checks++; if (early != 0) begin failures++; $display("FAIL chg_ok_early got=%0d want=0", early); end
    checks++; if (!done || !same_seq(req_q, want)) begin failures++; $display("FAIL chg_refetch got_n=%0d want_n=2", req_q.size()); end
    checks++; if (dout[95:64] !== exp_dout(2, 22'h41)) begin failures++; $display("FAIL chg_dout got=%h want=%h", dout[95:64], exp_dout(2, 22'h41)); end
  endtask

  task automatic test_delay_stray();
    bit done; int rdh; int perr0;
    mem_ovr[32'h123] = 16'h5A5A;
    ack_delay = 7; stray_en = 1'b1;
    perr0 = proto_err;
    req_q.delete();
    set_addr(0, 22'h123);
    wait_all(100, done, rdh);
    checks++; if (!done) begin failures++; $display("FAIL delay_timeout got=%b want=1", done); end
    checks++; if (rdh != 8) begin failures++; $display("FAIL delay_rd_hold got=%0d want=8", rdh); end
    checks++; if (proto_err != perr0) begin failures++; $display("FAIL delay_protocol got=%0d want=0", proto_err - perr0); end
    checks++; if (dout[31:0] !== 32'h00005A5A) begin failures++; $display("FAIL stray_dout got=%h want=00005a5a", dout[31:0]); end
    ack_delay = 0; stray_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] want[$];
    bit done; int rdh;
    set_addr(1, 22'h500);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.BA_RD !== 1'b0) begin failures++; $display("FAIL rstmid_ba_rd got=%b want=0", bus.BA_RD); end
    checks++; if (ok !== '0) begin failures++; $display("FAIL rstmid_ok got=%b want=0", ok); end
    checks++; if (dout !== '0) begin failures++; $display("FAIL rstmid_dout got=%h want=0", dout); end
    req_q.delete();
    wait_all(300, done, rdh);
    want = '{exp_ba(0, 22'h123), exp_ba(1, 22'h500), exp_ba(2, 22'h41), exp_ba(3, 22'h4200)};
    checks++; if (!done || !same_seq(req_q, want)) begin failures++; $display("FAIL rstmid_refetch got_n=%0d want_n=4", req_q.size()); end
    checks++; if (dout[63:32] !== exp_dout(1, 22'h500)) begin failures++; $display("FAIL rstmid_dout1 got=%h want=%h", dout[63:32], exp_dout(1, 22'h500)); end
  endtask

  // Reference: cache contents and round-robin position tracked from the arbitration rules
  task automatic test_random();
    bit            mvalid[NCH];
    logic [AW-1:0] mtag[NCH];
    logic [AW-1:0] a[NCH];
    logic [AW-1:0] want[$];
    int mlast, pick, c; bit done; int rdh;
    logic [NCH-1:0] p, ncs;
    cs = '0;
    do_reset();
    mlast = 0;
    for (int i = 0; i < NCH; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end
    for (int it = 0; it < 10; it++) begin
      ncs = NCH'($urandom_range(1, 15));
      for (int i = 0; i < NCH; i++) begin
        if (mvalid[i] && $urandom_range(0, 2) == 0) a[i] = mtag[i];
        else a[i] = AW'($urandom());
        set_addr(i, a[i]);
      end
      ack_delay = $urandom_range(0, 3);
      p = '0;
      for (int i = 0; i < NCH; i++) p[i] = ncs[i] && !(mvalid[i] && mtag[i] == a[i]);
      want.delete();
      while (p != 0) begin
        pick = -1;
        for (int i = 0; i < NCH; i++) if (pick < 0 && p[i] && PRIO[i]) pick = i;
        if (pick < 0) begin
          for (int k = 1; k <= NCH; k++) begin
            c = (mlast + k) % NCH;
            if (pick < 0 && p[c] && !PRIO[c]) pick = c;
          end
          mlast = pick;
        end
        want.push_back(exp_ba(pick, a[pick]));
        p[pick] = 1'b0; mvalid[pick] = 1'b1; mtag[pick] = a[pick];
      end
      req_q.delete();
      cs = ncs;
      wait_all(300, done, rdh);
      checks++; if (!done || !same_seq(req_q, want)) begin failures++; $display("FAIL rand_order it=%0d got_n=%0d want_n=%0d", it, req_q.size(), want.size()); end
      checks++; if (ok !== ncs) begin failures++; $display("FAIL rand_ok it=%0d got=%b want=%b", it, ok, ncs); end
      for (int i = 0; i < NCH; i++) begin
        if (mvalid[i]) begin
          checks++; if (dout[i*32 +: 32] !== exp_dout(i, mtag[i])) begin failures++; $display("FAIL rand_dout it=%0d ch=%0d got=%h want=%h", it, i, dout[i*32 +: 32], exp_dout(i, mtag[i])); end
        end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    ack_delay = 0; stray_en = 1'b0;
    test_reset();
    test_narrow();
    test_wide();
    test_wrap();
    test_prio_rr();
    test_addr_change();
    test_delay_stray();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
